alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_seq_pkg.sv | 51 +++++
 rtl/alu_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU command sequencer: command ops, external ALU ops,
// FSM states and the operand-to-ALU control mapping.
package alu_seq_pkg;

  localparam int unsigned W     = 16;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    CMD_AND = 3'd0,
    CMD_OR  = 3'd1,
    CMD_ADD = 3'd2,
    CMD_SUB = 3'd3,
    CMD_SLT = 3'd4,
    CMD_MUL = 3'd5
  } cmd_op_e;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SLT = 3'b011
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef struct packed {
    alu_op_e op;
    logic    bneg;
  } alu_ctl_t;

  // Single-cycle command to ALU control; SUB and SLT both subtract via BNegate.
  function automatic alu_ctl_t ctl_for(input logic [2:0] op);
    alu_ctl_t c;
    c.op   = ALU_AND;
    c.bneg = 1'b0;
    case (op)
      CMD_OR:  c.op = ALU_OR;
      CMD_ADD: c.op = ALU_ADD;
      CMD_SUB: begin c.op = ALU_ADD; c.bneg = 1'b1; end
      CMD_SLT: begin c.op = ALU_SLT; c.bneg = 1'b1; end
      default: c.op = ALU_AND;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Command sequencer around an external 16-bit ALU: single-cycle logic/arith ops
// and a 16-step shift-and-add multiply, with a held response handshake.
module alu_sequencer #(
  parameter int unsigned W         = 16,
  parameter int unsigned MUL_STEPS = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic         alu_bneg,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_result,
  input  logic         alu_zero,
  input  logic         alu_ovf,
  input  logic         alu_cout,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic         rsp_zero,
  output logic         rsp_ovf,
  output logic         rsp_cout,
  output logic         rsp_err
);
  import alu_seq_pkg::*;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MUL_STEPS - 1);

  state_e           state_q;
  logic             cmd_ready_q;
  logic             rsp_valid_q;
  logic [W-1:0]     rsp_data_q;
  logic             rsp_zero_q, rsp_ovf_q, rsp_cout_q, rsp_err_q;
  logic [W-1:0]     alu_a_q, alu_b_q;
  alu_op_e          alu_op_q;
  logic             alu_bneg_q;
  logic [W-1:0]     acc_q, m_q, q_q;
  logic [W-1:0]     acc_d, m_d, q_d;
  logic [CNT_W-1:0] cnt_q;
  logic             cout_q, ovf_q, cout_d, ovf_d;
  logic             add_step;
  alu_ctl_t         ctl;

  // One multiply step: conditional accumulate, shift, and sticky overflow tracking.
  always_comb begin
    add_step = q_q[0];
    acc_d    = add_step ? alu_result : acc_q;
    m_d      = m_q << 1;
    q_d      = q_q >> 1;
    cout_d   = cout_q | (add_step & alu_cout);
    // A bit leaving m matters only if a later multiplier bit would still use it.
    ovf_d    = ovf_q | (add_step & alu_cout) | (m_q[W-1] & (q_d != '0));
    ctl      = ctl_for(cmd_op);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      rsp_cout_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= ALU_AND;
      alu_bneg_q  <= 1'b0;
      acc_q       <= '0;
      m_q         <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            if (cmd_op == CMD_MUL) begin
              acc_q      <= '0;
              m_q        <= cmd_a;
              q_q        <= cmd_b;
              cnt_q      <= '0;
              cout_q     <= 1'b0;
              ovf_q      <= 1'b0;
              alu_a_q    <= '0;
              alu_b_q    <= cmd_a;
              alu_op_q   <= ALU_ADD;
              alu_bneg_q <= 1'b0;
              state_q    <= S_MUL;
            end else if (cmd_op > CMD_MUL) begin
              rsp_data_q  <= '0;
              rsp_zero_q  <= 1'b0;
              rsp_ovf_q   <= 1'b0;
              rsp_cout_q  <= 1'b0;
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              alu_a_q    <= cmd_a;
              alu_b_q    <= cmd_b;
              alu_op_q   <= ctl.op;
              alu_bneg_q <= ctl.bneg;
              state_q    <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          rsp_data_q  <= alu_result;
          rsp_zero_q  <= alu_zero;
          rsp_ovf_q   <= alu_ovf;
          rsp_cout_q  <= alu_cout;
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          alu_a_q     <= '0;
          alu_b_q     <= '0;
          alu_op_q    <= ALU_AND;
          alu_bneg_q  <= 1'b0;
          state_q     <= S_DONE;
        end
        S_MUL: begin
          acc_q  <= acc_d;
          m_q    <= m_d;
          q_q    <= q_d;
          cout_q <= cout_d;
          ovf_q  <= ovf_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            rsp_data_q  <= acc_d;
            rsp_zero_q  <= (acc_d == '0);
            rsp_ovf_q   <= ovf_d;
            rsp_cout_q  <= cout_d;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= ALU_AND;
            alu_bneg_q  <= 1'b0;
            state_q     <= S_DONE;
          end else begin
            alu_a_q <= acc_d;
            alu_b_q <= m_d;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_err   = rsp_err_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign alu_bneg  = alu_bneg_q;

endmodule
